fifo_pipe_out_server: RTL and testbench

- Buffered push-to-pull adapter. The producer pushes words in through a PipeIn-style enq method (server side). The consumer pulls words out through a PipeOut-style first/deq method pair (server side).
- Data path is a DEPTH-entry circular FIFO. It sits where a push-driven source feeds a block that consumes at its own pace, the reverse of a fifo-plus-out-to-in push adapter.
- Occupancy is exported for flow monitoring.

---
 rtl/fifo_pipe_out_server.sv | 93 +++++++++
 tb/tb_fifo_pipe_out_server.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pipe_out_server.sv
// Buffered push-to-pull adapter: producer pushes through enq, consumer pulls
// through first/deq. Storage is a depth-entry circular FIFO; occupancy is exported.
module fifo_pipe_out_server #(
  parameter int unsigned width  = 32,
  parameter int unsigned depth  = 4,
  parameter int unsigned cwidth = $clog2(depth + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_enq_ena_i,
  input  logic [width-1:0]  in_enq_v_i,
  output logic              in_enq_rdy_o,
  output logic [width-1:0]  out_first_o,
  output logic              out_first_rdy_o,
  input  logic              out_deq_ena_i,
  output logic              out_deq_rdy_o,
  output logic [cwidth-1:0] count
);

  // A depth of 1 still gets a 1-bit pointer, held at 0 by ptr_inc.
  localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;

  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [cwidth-1:0] cnt_q, cnt_d;
  logic [width-1:0]  head;
  logic              full, empty;
  logic              enq_fire, deq_fire;

  // Power-of-two depth lets the pointer wrap by natural overflow.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (depth == 1) return '0;
    return p + 1'b1;
  endfunction

  // Ready flags come from registered occupancy only, never from any strobe.
  always_comb begin
    full            = (cnt_q == cwidth'(depth));
    empty           = (cnt_q == '0);
    in_enq_rdy_o    = !full;
    out_first_rdy_o = !empty;
    out_deq_rdy_o   = !empty;
    enq_fire        = in_enq_ena_i && !full;
    deq_fire        = out_deq_ena_i && !empty;
    out_first_o     = empty ? '0 : head;
    count           = cnt_q;
  end

  // Pointer and occupancy next-state.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (enq_fire) wptr_d = ptr_inc(wptr_q);
    if (deq_fire) rptr_d = ptr_inc(rptr_q);
    case ({enq_fire, deq_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset clears it at once, discarding any same-cycle strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; out_first_o is masked to zero while empty instead.
  if (depth == 1) begin : g_single
    logic [width-1:0] word_q;
    // Single-entry storage written on accepted enq.
    always_ff @(posedge CLK) begin
      if (enq_fire && !RST) word_q <= in_enq_v_i;
    end
    assign head = word_q;
  end else begin : g_multi
    logic [width-1:0] mem [depth];
    // Circular storage written at the write pointer on accepted enq.
    always_ff @(posedge CLK) begin
      if (enq_fire && !RST) mem[wptr_q] <= in_enq_v_i;
    end
    assign head = mem[rptr_q];
  end

endmodule

// File: tb/tb_fifo_pipe_out_server.sv
// Scoreboard bench for fifo_pipe_out_server at depth=4/width=32 and depth=1/width=8.
module tb_fifo_pipe_out_server;

  logic        clk, rst;
  logic        enq4_ena, deq4_ena, enq4_rdy, first4_rdy, deq4_rdy;
  logic [31:0] enq4_v, first4;
  logic [2:0]  count4;
  logic        enq1_ena, deq1_ena, enq1_rdy, first1_rdy, deq1_rdy;
  logic [7:0]  enq1_v, first1;
  logic [0:0]  count1;
  logic        allow_illegal;

  int checks = 0;
  int failures = 0;

  logic [31:0] sb4[$];
  logic [7:0]  sb1[$];

  fifo_pipe_out_server #(.width(32), .depth(4)) dut4 (
    .CLK(clk), .RST(rst),
    .in_enq_ena_i(enq4_ena), .in_enq_v_i(enq4_v), .in_enq_rdy_o(enq4_rdy),
    .out_first_o(first4), .out_first_rdy_o(first4_rdy),
    .out_deq_ena_i(deq4_ena), .out_deq_rdy_o(deq4_rdy),
    .count(count4)
  );

  fifo_pipe_out_server #(.width(8), .depth(1)) dut1 (
    .CLK(clk), .RST(rst),
    .in_enq_ena_i(enq1_ena), .in_enq_v_i(enq1_v), .in_enq_rdy_o(enq1_rdy),
    .out_first_o(first1), .out_first_rdy_o(first1_rdy),
    .out_deq_ena_i(deq1_ena), .out_deq_rdy_o(deq1_rdy),
    .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobing a non-ready method is a protocol error unless a test does it on purpose.
  always @(posedge clk) begin
    if (!rst && !allow_illegal) begin
      assert (!(enq4_ena && !enq4_rdy)) else $error("illegal enq strobe on dut4");
      assert (!(deq4_ena && !deq4_rdy)) else $error("illegal deq strobe on dut4");
      assert (!(enq1_ena && !enq1_rdy)) else $error("illegal enq strobe on dut1");
      assert (!(deq1_ena && !deq1_rdy)) else $error("illegal deq strobe on dut1");
    end
  end

  // One cycle on dut4: drive strobes, update the model, return the head seen before the edge.
  task automatic step4(input logic e, input logic [31:0] v, input logic d,
                       output logic popped, output logic [31:0] got, output logic [31:0] exp);
    logic ef, df;
    enq4_ena = e; enq4_v = v; deq4_ena = d;
    ef = e && (sb4.size() < 4);
    df = d && (sb4.size() > 0);
    popped = df; got = first4; exp = '0;
    if (df) exp = sb4.pop_front();
    if (ef) sb4.push_back(v);
    @(posedge clk); #1;
    enq4_ena = 1'b0; deq4_ena = 1'b0;
  endtask

  task automatic step1(input logic e, input logic [7:0] v, input logic d,
                       output logic popped, output logic [7:0] got, output logic [7:0] exp);
    logic ef, df;
    enq1_ena = e; enq1_v = v; deq1_ena = d;
    ef = e && (sb1.size() < 1);
    df = d && (sb1.size() > 0);
    popped = df; got = first1; exp = '0;
    if (df) exp = sb1.pop_front();
    if (ef) sb1.push_back(v);
    @(posedge clk); #1;
    enq1_ena = 1'b0; deq1_ena = 1'b0;
  endtask

  task automatic test_reset();
    logic p; logic [31:0] g, x;
    rst = 1'b1;
    #1;
    checks++;
    if ({enq4_rdy, first4_rdy, deq4_rdy, count4, first4} !== {1'b1, 1'b0, 1'b0, 3'd0, 32'h0}) begin
      failures++;
      $display("FAIL reset_state got rdy/frdy/drdy/cnt/first=%b/%b/%b/%0d/%0h want 1/0/0/0/0",
               enq4_rdy, first4_rdy, deq4_rdy, count4, first4);
    end
    checks++;
    if ({enq1_rdy, first1_rdy, count1} !== {1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state_d1 got rdy/frdy/cnt=%b/%b/%0d want 1/0/0", enq1_rdy, first1_rdy, count1);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Mid-stream asynchronous reset.
    step4(1'b1, 32'hA1, 1'b0, p, g, x);
    step4(1'b1, 32'hA2, 1'b0, p, g, x);
    checks++;
    if (count4 !== 3'd2) begin
      failures++; $display("FAIL pre_reset_count got=%0d want=2", count4);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (count4 !== 3'd0 || first4_rdy !== 1'b0 || first4 !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got cnt=%0d frdy=%b first=%0h want 0/0/0", count4, first4_rdy, first4);
    end
    sb4.delete(); sb1.delete();
    @(posedge clk); #1 rst = 1'b0;
    step4(1'b1, 32'hB0, 1'b0, p, g, x);
    checks++;
    if (first4 !== 32'hB0 || count4 !== 3'd1) begin
      failures++; $display("FAIL post_reset_enq got first=%0h cnt=%0d want b0/1", first4, count4);
    end
    step4(1'b0, 32'h0, 1'b1, p, g, x);
    checks++;
    if (!p || g !== x) begin
      failures++; $display("FAIL post_reset_deq got=%0h want=%0h", g, x);
    end
  endtask

  task automatic test_fill();
    logic p; logic [31:0] g, x;
    for (int i = 0; i < 4; i++) step4(1'b1, 32'h10 + i, 1'b0, p, g, x);
    checks++;
    if (count4 !== 3'd4 || enq4_rdy !== 1'b0) begin
      failures++; $display("FAIL full got cnt=%0d rdy=%b want 4/0", count4, enq4_rdy);
    end
    allow_illegal = 1'b1;
    step4(1'b1, 32'h14, 1'b0, p, g, x);
    allow_illegal = 1'b0;
    checks++;
    if (count4 !== 3'd4 || first4 !== 32'h10) begin
      failures++; $display("FAIL full_enq_ignored got cnt=%0d first=%0h want 4/10", count4, first4);
    end
    for (int i = 0; i < 4; i++) begin
      step4(1'b0, 32'h0, 1'b1, p, g, x);
      checks++;
      if (!p || g !== x) begin
        failures++; $display("FAIL fill_drain[%0d] got=%0h want=%0h", i, g, x);
      end
    end
    checks++;
    if (deq4_rdy !== 1'b0 || first4 !== 32'h0 || count4 !== 3'd0) begin
      failures++;
      $display("FAIL drained got drdy=%b first=%0h cnt=%0d want 0/0/0", deq4_rdy, first4, count4);
    end
  endtask

  task automatic test_wrap();
    logic p; logic [31:0] g, x;
    step4(1'b1, 32'd0, 1'b0, p, g, x);
    step4(1'b1, 32'd1, 1'b0, p, g, x);
    for (int i = 2; i < 12; i++) begin
      step4(i < 10, 32'(i), 1'b1, p, g, x);
      checks++;
      if (!p || g !== x || g !== 32'(i - 2)) begin
        failures++; $display("FAIL wrap_out[%0d] got=%0h want=%0h", i - 2, g, i - 2);
      end
      if (i < 10) begin
        checks++;
        if (count4 !== 3'd2) begin
          failures++; $display("FAIL wrap_count[%0d] got=%0d want=2", i - 2, count4);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic p; logic [31:0] g, x;
    step4(1'b1, 32'h55, 1'b0, p, g, x);
    step4(1'b1, 32'h66, 1'b1, p, g, x);
    checks++;
    if (!p || g !== 32'h55 || count4 !== 3'd1 || first4 !== 32'h66) begin
      failures++;
      $display("FAIL simul_c1 got out=%0h cnt=%0d first=%0h want 55/1/66", g, count4, first4);
    end
    step4(1'b0, 32'h0, 1'b1, p, g, x);
    for (int i = 1; i <= 4; i++) step4(1'b1, 32'(i), 1'b0, p, g, x);
    allow_illegal = 1'b1;
    step4(1'b1, 32'h99, 1'b1, p, g, x);
    allow_illegal = 1'b0;
    checks++;
    if (!p || g !== 32'h1 || count4 !== 3'd3 || first4 !== 32'h2) begin
      failures++;
      $display("FAIL simul_full got out=%0h cnt=%0d first=%0h want 1/3/2", g, count4, first4);
    end
    for (int i = 0; i < 3; i++) begin
      step4(1'b0, 32'h0, 1'b1, p, g, x);
      checks++;
      if (!p || g !== x) begin
        failures++; $display("FAIL simul_drain[%0d] got=%0h want=%0h", i, g, x);
      end
    end
  endtask

  task automatic test_depth1();
    logic p, e, d; logic [7:0] g, x;
    step1(1'b1, 8'hFF, 1'b0, p, g, x);
    checks++;
    if (enq1_rdy !== 1'b0 || first1 !== 8'hFF || count1 !== 1'b1) begin
      failures++;
      $display("FAIL d1_enq got rdy=%b first=%0h cnt=%0d want 0/ff/1", enq1_rdy, first1, count1);
    end
    step1(1'b0, 8'h0, 1'b1, p, g, x);
    checks++;
    if (!p || g !== 8'hFF || count1 !== 1'b0) begin
      failures++; $display("FAIL d1_deq got out=%0h cnt=%0d want ff/0", g, count1);
    end
    for (int i = 0; i < 1000; i++) begin
      e = ($urandom_range(0, 1) == 1) && (sb1.size() == 0);
      d = ($urandom_range(0, 1) == 1) && (sb1.size() == 1);
      step1(e, 8'($urandom), d, p, g, x);
      if (p) begin
        checks++;
        if (g !== x) begin
          failures++; $display("FAIL d1_rand_out[%0d] got=%0h want=%0h", i, g, x);
        end
      end
      checks++;
      if (count1 !== 1'(sb1.size())) begin
        failures++; $display("FAIL d1_rand_count[%0d] got=%0d want=%0d", i, count1, sb1.size());
      end
    end
  endtask

  task automatic test_latency();
    logic p; logic [31:0] g, x;
    enq4_ena = 1'b1; enq4_v = 32'h3C;
    #2;
    checks++;
    if (first4_rdy !== 1'b0 || first4 !== 32'h0) begin
      failures++; $display("FAIL latency_cycle_n got frdy=%b first=%0h want 0/0", first4_rdy, first4);
    end
    sb4.push_back(32'h3C);
    @(posedge clk); #1;
    enq4_ena = 1'b0;
    checks++;
    if (first4_rdy !== 1'b1 || first4 !== 32'h3C) begin
      failures++; $display("FAIL latency_cycle_n1 got frdy=%b first=%0h want 1/3c", first4_rdy, first4);
    end
    step4(1'b0, 32'h0, 1'b1, p, g, x);
    checks++;
    if (!p || g !== x) begin
      failures++; $display("FAIL latency_deq got=%0h want=%0h", g, x);
    end
  endtask

  initial begin
    allow_illegal = 1'b0;
    enq4_ena = 1'b0; deq4_ena = 1'b0; enq4_v = '0;
    enq1_ena = 1'b0; deq1_ena = 1'b0; enq1_v = '0;
    test_reset();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_depth1();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
